cpu_step_ctrl: RTL and testbench

- Consumes the divided clock produced by the board clock divider and turns it into a one-`clk`-cycle CPU clock-enable pulse, `cpu_en`, for the MIPS pipeline.
- Operating modes:
  - HALT: no pulses.
  - RUN: one pulse per divided-clock period.
  - STEP: one pulse per debounced button press.
  - BURST: `burst_len` pulses per press.
- Sits between the clock divider and the pipeline's register enables.
- Also keeps an executed-cycle counter for the display logic.

---
 rtl/cpu_step_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/cpu_step_ctrl.sv | 110 +++++++++++
 tb/tb_cpu_step_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_step_pkg: shared mode/state encodings and widths for cpu_step_ctrl.
// Revision: 1.0
// ----------------------------------------------------------------------------
package cpu_step_pkg;

    localparam int BURST_W = 8;
    localparam int CNT_W   = 32;

    typedef enum logic [1:0] {
        MODE_HALT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_ARMED = 2'b10,
        ST_BURST = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_debounce: synchronises a raw button and emits a one-cycle press pulse.
// Revision: 1.0
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned      DEB_W   = 20,
    parameter logic [DEB_W-1:0] DEB_CNT = DEB_W'(1000000)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    logic [1:0]       sync_q;
    logic             stable_q, stable_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    // Only a level held for DEB_CNT cycles is accepted; a release is accepted silently.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == DEB_CNT - 1'b1) begin
                stable_d = sync_q[1];
                press_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_step_ctrl: turns the divided clock into HALT/RUN/STEP/BURST CPU enables.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int unsigned      DEB_W   = 20,
    parameter logic [DEB_W-1:0] DEB_CNT = DEB_W'(1000000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_clk,
    input  logic [1:0]         mode,
    input  logic               step_btn,
    input  logic [BURST_W-1:0] burst_len,
    output logic               cpu_en,
    output logic               busy,
    output logic [CNT_W-1:0]   cycle_cnt
);

    logic               tick_q;
    logic               tick_rise;
    logic               press;
    state_e             state_q, state_d;
    logic [BURST_W-1:0] remain_q, remain_d;
    logic               cpu_en_q, pulse_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    btn_debounce #(
        .DEB_W   (DEB_W),
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (step_btn),
        .press_o (press)
    );

    assign tick_rise = tick_clk & ~tick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q   <= 1'b0;
            state_q  <= ST_IDLE;
            remain_q <= '0;
            cpu_en_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            tick_q   <= tick_clk;
            state_q  <= state_d;
            remain_q <= remain_d;
            cpu_en_q <= pulse_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    // A press in IDLE only arms; the pulse waits for a later tick rise.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        case (state_q)
            ST_IDLE: begin
                if (mode == MODE_RUN) begin
                    state_d = ST_RUN;
                end else if (mode == MODE_STEP && press) begin
                    state_d = ST_ARMED;
                end else if (mode == MODE_BURST && press && burst_len != '0) begin
                    state_d  = ST_BURST;
                    remain_d = burst_len;
                end
            end
            ST_RUN: begin
                if (mode != MODE_RUN) state_d = ST_IDLE;
            end
            ST_ARMED: begin
                if (mode != MODE_STEP || tick_rise) state_d = ST_IDLE;
            end
            ST_BURST: begin
                if (mode != MODE_BURST) begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                end else if (tick_rise) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == BURST_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pulse_d = tick_rise &&
                  ((state_q == ST_RUN   && mode == MODE_RUN)  ||
                   (state_q == ST_ARMED && mode == MODE_STEP) ||
                   (state_q == ST_BURST && mode == MODE_BURST));
        busy_d  = (state_d == ST_ARMED) || (state_d == ST_BURST);
        cnt_d   = cnt_q + CNT_W'(pulse_d);
    end

    assign cpu_en    = cpu_en_q;
    assign busy      = busy_q;
    assign cycle_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cpu_step_ctrl: scoreboard bench for cpu_step_ctrl (DEB_CNT=4, tick = clk/8).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cpu_step_ctrl;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        tick_clk  = 1'b0;
    logic [1:0]  mode      = 2'b01;
    logic        step_btn  = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic        cpu_en;
    logic        busy;
    logic [31:0] cycle_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cnt = 32'd0;
    int          tdiv = 0;
    logic        tprev = 1'b0;
    logic        edge_rise = 1'b0;

    cpu_step_ctrl #(
        .DEB_W   (20),
        .DEB_CNT (20'd4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_clk  (tick_clk),
        .mode      (mode),
        .step_btn  (step_btn),
        .burst_len (burst_len),
        .cpu_en    (cpu_en),
        .busy      (busy),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv     = tdiv + 1;
        tick_clk = ((tdiv % 8) >= 4);
    end

    // Flags whether the DUT saw a tick rise on the edge that just passed.
    always @(posedge clk) begin
        edge_rise = tick_clk & ~tprev;
        tprev     = tick_clk;
    end

    function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && cpu_en) begin
            check("pulse_align", {31'd0, edge_rise}, 32'd1);
            if (exp_q.size() == 0) check("unexpected_pulse", cycle_cnt, 32'hDEAD_BEEF);
            else                   check("pulse_cnt", cycle_cnt, exp_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input int n);
        repeat (n) begin
            exp_cnt = exp_cnt + 32'd1;
            exp_q.push_back(exp_cnt);
        end
    endtask

    task automatic wait_size(input string nm, input int sz, input int budget);
        int i = 0;
        while (exp_q.size() > sz && i < budget) begin
            cyc(1);
            i++;
        end
        check(nm, exp_q.size(), sz);
    endtask

    initial begin
        int  i;
        logic seen;

        // reset, RUN
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_cnt", cycle_cnt, 32'd0);
        end
        reset = 1'b0;
        push(4);
        wait_size("run_pulses", 0, 60);
        mode = 2'b00;
        check("run_cnt", cycle_cnt, 32'd4);
        cyc(10);

        // STEP with a bouncy button held long
        mode = 2'b10;
        push(1);
        cyc(2);
        step_btn = 1'b1; cyc(1);
        step_btn = 1'b0; cyc(1);
        step_btn = 1'b1;
        seen = 1'b0;
        i = 0;
        while (!seen && i < 20) begin
            cyc(1);
            seen = busy;
            i++;
        end
        check("step_busy", {31'd0, seen}, 32'd1);
        wait_size("step_pulse", 0, 20);
        cyc(24);
        check("step_idle_busy", {31'd0, busy}, 32'd0);
        step_btn = 1'b0;
        cyc(12);

        // BURST of 3 with a second press during the burst
        mode = 2'b11;
        burst_len = 8'd3;
        push(3);
        step_btn = 1'b1; cyc(8); step_btn = 1'b0;
        wait_size("burst3_first", 2, 30);
        cyc(6);
        step_btn = 1'b1; cyc(8); step_btn = 1'b0;
        check("burst3_busy_mid", {31'd0, busy}, 32'd1);
        wait_size("burst3_all", 0, 40);
        check("burst3_busy_end", {31'd0, busy}, 32'd0);
        cyc(30);
        check("burst3_cnt", cycle_cnt, 32'd8);

        // BURST length 0 is ignored, then length 2
        burst_len = 8'd0;
        seen = 1'b0;
        step_btn = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 8) step_btn = 1'b0;
            cyc(1);
            seen = seen | busy;
        end
        check("len0_busy", {31'd0, seen}, 32'd0);
        burst_len = 8'd2;
        push(2);
        step_btn = 1'b1; cyc(8); step_btn = 1'b0;
        wait_size("burst2", 0, 40);
        cyc(12);

        // abort a BURST of 5 after two pulses
        reset = 1'b1;
        mode = 2'b00;
        cyc(2);
        reset = 1'b0;
        exp_cnt = 32'd0;
        mode = 2'b11;
        burst_len = 8'd5;
        push(2);
        step_btn = 1'b1; cyc(8); step_btn = 1'b0;
        wait_size("burst5_two", 0, 40);
        mode = 2'b00;
        cyc(1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        cyc(40);
        check("abort_cnt", cycle_cnt, 32'd2);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFE;
        cyc(2);
        release dut.cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
        mode = 2'b01;
        push(2);
        wait_size("wrap", 0, 40);
        mode = 2'b00;
        check("wrap_cnt", cycle_cnt, 32'd0);
        cyc(10);

        // reset in the middle of a pulse
        mode = 2'b01;
        push(1);
        i = 0;
        while (!cpu_en && i < 30) begin
            cyc(1);
            i++;
        end
        check("mid_pulse_seen", {31'd0, cpu_en}, 32'd1);
        reset = 1'b1;
        mode = 2'b00;
        #1;
        check("rst_mid_en", {31'd0, cpu_en}, 32'd0);
        check("rst_mid_cnt", cycle_cnt, 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(20);
        check("final_queue", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
